// File: rtl/stopwatch_cu.sv
// -----------------------------------------------------------------------------
// stopwatch_cu -- stopwatch control unit
//
// Merges debounced button pulses with UART command bytes into a single event
// stream and sequences the datapath through STOP / RUN / CLEAR.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   -> lap snapshot ports/registers present; CMD_LAP honoured in RUN
//   undefined -> no lap hardware; CMD_LAP bytes ignored like any other byte
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   i_btn_runstop  one-cycle run/stop pulse from debouncer
//   i_btn_clear    one-cycle clear pulse from debouncer
//   i_rx_data      UART RX byte, valid when i_rx_done=1
//   i_rx_done      one-cycle UART byte strobe
//   i_msec/i_sec/i_min/i_hour  live datapath time (lap snapshot source)
//   o_runstop      1 = datapath tick generator enabled (state RUN)
//   o_clear        clear strobe to datapath counters (state CLEAR)
//   o_state        2'b00 STOP, 2'b01 RUN, 2'b10 CLEAR
//   o_lap_*        lap snapshot (STOPWATCH_LAP_EN only)
//   o_lap_valid    one-cycle pulse when a new lap is captured (STOPWATCH_LAP_EN only)
// -----------------------------------------------------------------------------
module stopwatch_cu #(
    parameter logic [7:0] CMD_RUNSTOP  = 8'h52,
    parameter logic [7:0] CMD_CLEAR    = 8'h43,
    parameter logic [7:0] CMD_LAP      = 8'h4C,
    parameter int         CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_runstop,
    input  logic       i_btn_clear,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
`ifdef STOPWATCH_LAP_EN
    output logic [6:0] o_lap_msec,
    output logic [5:0] o_lap_sec,
    output logic [5:0] o_lap_min,
    output logic [4:0] o_lap_hour,
    output logic       o_lap_valid,
`endif
    output logic       o_runstop,
    output logic       o_clear,
    output logic [1:0] o_state
);

    localparam int                CNT_W    = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ev_rs, ev_clr;

    // Case-insensitive ASCII compare: setting bit 5 folds upper onto lower case.
    function automatic logic byte_match(input logic [7:0] b, input logic [7:0] cmd);
        return (b | 8'h20) == (cmd | 8'h20);
    endfunction

    // Button and UART requests for the same action in one cycle collapse into
    // a single event, so they never produce a double toggle.
    assign ev_rs  = i_btn_runstop | (i_rx_done & byte_match(i_rx_data, CMD_RUNSTOP));
    assign ev_clr = i_btn_clear   | (i_rx_done & byte_match(i_rx_data, CMD_CLEAR));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_STOP: begin
                if (ev_clr)
                    state_d = ST_CLEAR;
                else if (ev_rs)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                // Clear requests are deliberately ignored while running.
                if (ev_rs)
                    state_d = ST_STOP;
            end
            ST_CLEAR: begin
                // Events are dropped here, not queued.
                if (cnt_q == CNT_LAST)
                    state_d = ST_STOP;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_STOP;
        endcase
    end

    // ---- state / counter register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registers only; no input-to-output combinational path.
    assign o_runstop = (state_q == ST_RUN);
    assign o_clear   = (state_q == ST_CLEAR);
    assign o_state   = state_q;

`ifdef STOPWATCH_LAP_EN
    logic       lap_ev;
    logic       lap_vld_p1;
    logic [6:0] lap_msec_p1;
    logic [5:0] lap_sec_p1;
    logic [5:0] lap_min_p1;
    logic [4:0] lap_hour_p1;

    assign lap_ev = i_rx_done & byte_match(i_rx_data, CMD_LAP);

    // ---- lap snapshot register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_vld_p1  <= 1'b0;
            lap_msec_p1 <= '0;
            lap_sec_p1  <= '0;
            lap_min_p1  <= '0;
            lap_hour_p1 <= '0;
        end else begin
            lap_vld_p1 <= 1'b0;
            if (state_q == ST_STOP && ev_clr) begin
                lap_msec_p1 <= '0;
                lap_sec_p1  <= '0;
                lap_min_p1  <= '0;
                lap_hour_p1 <= '0;
            end else if (state_q == ST_RUN && lap_ev) begin
                lap_vld_p1  <= 1'b1;
                lap_msec_p1 <= i_msec;
                lap_sec_p1  <= i_sec;
                lap_min_p1  <= i_min;
                lap_hour_p1 <= i_hour;
            end
        end
    end

    assign o_lap_valid = lap_vld_p1;
    assign o_lap_msec  = lap_msec_p1;
    assign o_lap_sec   = lap_sec_p1;
    assign o_lap_min   = lap_min_p1;
    assign o_lap_hour  = lap_hour_p1;
`else
    // Time inputs only feed the lap snapshot, which is absent in this build.
    logic unused_time;
    assign unused_time = ^{i_msec, i_sec, i_min, i_hour};
`endif

endmodule

// File: tb/tb_stopwatch_cu.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_cu -- directed, table-driven bench for stopwatch_cu
// -----------------------------------------------------------------------------
module tb_stopwatch_cu;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_rs, btn_clr, rx_done;
    logic [7:0] rx_data;
    logic [6:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       runstop, clear;
    logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
    logic [6:0] lap_msec;
    logic [5:0] lap_sec, lap_min;
    logic [4:0] lap_hour;
    logic       lap_valid;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_cu dut (
        .clk           (clk),
        .rst           (rst),
        .i_btn_runstop (btn_rs),
        .i_btn_clear   (btn_clr),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .i_msec        (msec),
        .i_sec         (sec),
        .i_min         (min),
        .i_hour        (hour),
`ifdef STOPWATCH_LAP_EN
        .o_lap_msec    (lap_msec),
        .o_lap_sec     (lap_sec),
        .o_lap_min     (lap_min),
        .o_lap_hour    (lap_hour),
        .o_lap_valid   (lap_valid),
`endif
        .o_runstop     (runstop),
        .o_clear       (clear),
        .o_state       (state)
    );

    typedef struct {
        logic       rs;
        logic       clr;
        logic       done;
        logic [7:0] data;
        logic       exp_rs;
        logic       exp_clr;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, input logic clr, input logic done,
                       input logic [7:0] data, input logic [1:0] exp_state);
        vec_t v;
        v.rs        = rs;
        v.clr       = clr;
        v.done      = done;
        v.data      = data;
        v.exp_state = exp_state;
        v.exp_rs    = (exp_state == 2'b01);
        v.exp_clr   = (exp_state == 2'b10);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input logic [1:0] exp_state);
        chk({nm, "_state"},   int'(state),   int'(exp_state));
        chk({nm, "_runstop"}, int'(runstop), int'(exp_state == 2'b01));
        chk({nm, "_clear"},   int'(clear),   int'(exp_state == 2'b10));
    endtask

    // Drive at the falling edge, then advance past the next rising edge.
    task automatic cyc(input logic r, input logic rs, input logic clr,
                       input logic done, input logic [7:0] data);
        @(negedge clk);
        rst     = r;
        btn_rs  = rs;
        btn_clr = clr;
        rx_done = done;
        rx_data = data;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] S_STOP = 2'b00, S_RUN = 2'b01, S_CLR = 2'b10;

    initial begin
        rst = 1'b1; btn_rs = 0; btn_clr = 0; rx_done = 0; rx_data = 8'h00;
        msec = 0; sec = 0; min = 0; hour = 0;

        // Reset for two clocks, then release.
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        chk_outs("reset", S_STOP);

        // Vector table: inputs for one cycle, outputs expected after that edge.
        add(0, 0, 0, 8'h00, S_STOP);
        add(1, 0, 0, 8'h00, S_RUN);                       // button start
        for (int i = 0; i < 9; i++) add(0, 0, 0, 8'h00, S_RUN);
        add(1, 0, 0, 8'h00, S_STOP);                      // stop 10 clk later
        add(0, 0, 1, 8'h63, S_CLR);                       // 'c' in STOP
        add(0, 0, 0, 8'h00, S_CLR);                       // second strobe cycle
        add(0, 0, 0, 8'h00, S_STOP);                      // strobe exactly 2
        add(1, 0, 0, 8'h00, S_RUN);
        add(0, 0, 1, 8'h43, S_RUN);                       // 'C' while running
        add(0, 1, 0, 8'h00, S_RUN);                       // clear button while running
        add(0, 0, 1, 8'h72, S_STOP);                      // 'r' stops
        add(1, 0, 1, 8'h72, S_RUN);                       // button + 'r' = one toggle
        add(0, 0, 0, 8'h00, S_RUN);
        add(1, 0, 0, 8'h00, S_STOP);
        add(0, 1, 0, 8'h00, S_CLR);                       // clear button
        add(1, 0, 1, 8'h52, S_CLR);                       // events dropped in CLEAR
        add(0, 0, 0, 8'h00, S_STOP);
        add(0, 0, 0, 8'h00, S_STOP);                      // not queued
        add(0, 0, 1, 8'h58, S_STOP);                      // 'X' ignored
        add(1, 1, 0, 8'h00, S_CLR);                       // clear beats run in STOP
        add(0, 0, 0, 8'h00, S_CLR);
        add(0, 0, 0, 8'h00, S_STOP);
        add(0, 0, 1, 8'h4C, S_STOP);                      // 'L' never starts
        add(0, 0, 0, 8'h52, S_STOP);                      // 'R' without rx_done
        add(0, 0, 1, 8'h52, S_RUN);                       // 'R' with rx_done
        add(0, 0, 1, 8'h58, S_RUN);                       // 'X' ignored in RUN
        add(0, 0, 1, 8'h52, S_STOP);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(0, vecs[i].rs, vecs[i].clr, vecs[i].done, vecs[i].data);
            chk($sformatf("vec%0d_state", i),   int'(state),   int'(vecs[i].exp_state));
            chk($sformatf("vec%0d_runstop", i), int'(runstop), int'(vecs[i].exp_rs));
            chk($sformatf("vec%0d_clear", i),   int'(clear),   int'(vecs[i].exp_clr));
        end

        // Reset during CLEAR truncates the strobe with no residual pulse.
        cyc(0, 0, 1, 0, 8'h00);  chk_outs("rclr_enter", S_CLR);
        cyc(1, 0, 0, 0, 8'h00);  chk_outs("rclr_rst",   S_STOP);
        cyc(0, 0, 0, 0, 8'h00);  chk_outs("rclr_after", S_STOP);
        // Counter restarted: a fresh clear is again exactly two cycles.
        cyc(0, 0, 1, 0, 8'h00);  chk_outs("rclr_c1", S_CLR);
        cyc(0, 0, 0, 0, 8'h00);  chk_outs("rclr_c2", S_CLR);
        cyc(0, 0, 0, 0, 8'h00);  chk_outs("rclr_c3", S_STOP);

        // Reset during RUN, and reset overriding a simultaneous start.
        cyc(0, 1, 0, 0, 8'h00);  chk_outs("rrun_run", S_RUN);
        cyc(1, 0, 0, 0, 8'h00);  chk_outs("rrun_rst", S_STOP);
        cyc(1, 1, 0, 0, 8'h00);  chk_outs("rst_ev",   S_STOP);
        cyc(0, 0, 0, 0, 8'h00);  chk_outs("rst_rel",  S_STOP);

`ifdef STOPWATCH_LAP_EN
        cyc(0, 1, 0, 0, 8'h00);  chk_outs("lap_run", S_RUN);
        hour = 5'd0; min = 6'd1; sec = 6'd23; msec = 7'd45;
        cyc(0, 0, 0, 1, 8'h4C);
        chk("lap_valid", int'(lap_valid), 1);
        chk("lap_msec",  int'(lap_msec), 45);
        chk("lap_sec",   int'(lap_sec),  23);
        chk("lap_min",   int'(lap_min),  1);
        chk("lap_hour",  int'(lap_hour), 0);
        sec = 6'd30; msec = 7'd7;
        cyc(0, 0, 0, 0, 8'h00);
        chk("lap_pulse_end", int'(lap_valid), 0);
        chk("lap_hold_sec",  int'(lap_sec),  23);
        cyc(0, 0, 0, 1, 8'h6C);                           // lowercase 'l'
        chk("lap2_valid", int'(lap_valid), 1);
        chk("lap2_sec",   int'(lap_sec),  30);
        chk("lap2_msec",  int'(lap_msec), 7);
        cyc(0, 1, 0, 0, 8'h00);  chk_outs("lap_stop", S_STOP);
        sec = 6'd50;
        cyc(0, 0, 0, 1, 8'h4C);
        chk("lap_stop_valid", int'(lap_valid), 0);
        chk("lap_stop_sec",   int'(lap_sec),  30);
        cyc(0, 0, 1, 0, 8'h00);
        chk("lap_clr_sec",  int'(lap_sec),  0);
        chk("lap_clr_msec", int'(lap_msec), 0);
        chk("lap_clr_min",  int'(lap_min),  0);
`endif

        @(negedge clk);
        btn_rs = 0; btn_clr = 0; rx_done = 0; rst = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
